// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: PC register, imem handshake, decode hold, branch redirect
`ifndef WORD
`define WORD 64
`endif

module fetch_controller #(
  parameter int               WIDTH    = `WORD,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               INC      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      delivered_count
);

  typedef enum logic [1:0] {BOOT, FETCH, DELIVER} state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt, instr_pc_nxt, target_aligned;
  logic [31:0]      instr_nxt, count_nxt;

  assign target_aligned = branch_target & ALIGN_MASK;
  assign imem_req       = (state == FETCH);
  assign instr_valid    = (state == DELIVER);
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= BOOT;
      pc              <= RESET_PC;
      instr           <= '0;
      instr_pc        <= '0;
      delivered_count <= '0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      instr           <= instr_nxt;
      instr_pc        <= instr_pc_nxt;
      delivered_count <= count_nxt;
    end
  end

  // Branch outranks both a same-cycle ack and a decode stall.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    count_nxt    = delivered_count;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (branch_taken) begin
          pc_nxt = target_aligned;
        end else if (imem_ack) begin
          instr_nxt    = imem_data;
          instr_pc_nxt = pc;
          pc_nxt       = pc + INC_W;
          state_nxt    = DELIVER;
        end
      end
      DELIVER: begin
        if (branch_taken) begin
          pc_nxt    = target_aligned;
          state_nxt = FETCH;
        end else if (!stall) begin
          count_nxt = delivered_count + 32'd1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed table, randomized model comparison and reset/wrap checks for fetch_controller
module tb_fetch_controller;

  logic        clk, reset, stall, branch_taken, imem_ack;
  logic [63:0] branch_target;
  logic [31:0] imem_data;
  logic        imem_req, instr_valid;
  logic [63:0] imem_addr, instr_pc, pc;
  logic [31:0] instr, delivered_count;

  logic        w_reset, w_one, w_zero;
  logic [63:0] w_target;
  logic [31:0] w_data;
  logic        w_req, w_valid;
  logic [63:0] w_addr, w_ipc, w_pc;
  logic [31:0] w_instr, w_count;

  int errors = 0;
  int checks = 0;

  fetch_controller dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .pc(pc), .delivered_count(delivered_count)
  );

  fetch_controller #(.WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .INC(4)) dut_wrap (
    .clk(clk), .reset(w_reset), .stall(w_zero), .branch_taken(w_zero),
    .branch_target(w_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_one), .imem_data(w_data), .instr(w_instr), .instr_pc(w_ipc),
    .instr_valid(w_valid), .pc(w_pc), .delivered_count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, branch, ack;
    logic [63:0] target;
    logic [31:0] data;
    logic        req, valid;
    logic [63:0] pc, ipc;
    logic [31:0] instr, count;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic s, logic b, logic a, logic [63:0] t, logic [31:0] d,
                              logic rq, logic v, logic [63:0] p, logic [63:0] ip,
                              logic [31:0] ins, logic [31:0] c);
    vec_t r;
    r.stall = s; r.branch = b; r.ack = a; r.target = t; r.data = d;
    r.req = rq; r.valid = v; r.pc = p; r.ipc = ip; r.instr = ins; r.count = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: "booting" for the one cycle after reset, "holding" while an instruction is offered.
  logic        m_booting, m_holding;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_count;

  task automatic model_reset();
    m_booting = 1'b1; m_holding = 1'b0; m_pc = 64'd0; m_ipc = 64'd0;
    m_instr = 32'd0; m_count = 32'd0;
  endtask

  task automatic model_step();
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (branch_taken) begin
      m_pc = {branch_target[63:2], 2'b00};
      m_holding = 1'b0;
    end else if (!m_holding && imem_ack) begin
      m_instr = imem_data; m_ipc = m_pc; m_pc = m_pc + 64'd4; m_holding = 1'b1;
    end else if (m_holding && !stall) begin
      m_count = m_count + 32'd1; m_holding = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    branch_target = '0; imem_data = '0;
    w_reset = 1'b0; w_one = 1'b1; w_zero = 1'b0; w_target = '0; w_data = 32'h1234_5678;

    vecs[0]  = mk(0, 0, 1, 0,      32'hA0,   1, 0, 64'h0,   64'h0,   32'h0,    0);
    vecs[1]  = mk(0, 0, 1, 0,      32'hA0,   0, 1, 64'h4,   64'h0,   32'hA0,   0);
    vecs[2]  = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h4,   64'h0,   32'h0,    1);
    vecs[3]  = mk(0, 0, 1, 0,      32'hA4,   0, 1, 64'h8,   64'h4,   32'hA4,   1);
    vecs[4]  = mk(1, 0, 1, 0,      32'hEE,   0, 1, 64'h8,   64'h4,   32'hA4,   1);
    vecs[5]  = mk(1, 0, 0, 0,      32'hEE,   0, 1, 64'h8,   64'h4,   32'hA4,   1);
    vecs[6]  = mk(1, 0, 1, 0,      32'hEE,   0, 1, 64'h8,   64'h4,   32'hA4,   1);
    vecs[7]  = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h8,   64'h0,   32'h0,    2);
    vecs[8]  = mk(0, 1, 1, 64'h103, 32'hA8,  1, 0, 64'h100, 64'h0,   32'h0,    2);
    vecs[9]  = mk(0, 0, 1, 0,      32'hDEAD, 0, 1, 64'h104, 64'h100, 32'hDEAD, 2);
    vecs[10] = mk(1, 1, 0, 64'h200, 32'h0,   1, 0, 64'h200, 64'h0,   32'h0,    2);
    vecs[11] = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h200, 64'h0,   32'h0,    2);
    vecs[12] = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h200, 64'h0,   32'h0,    2);
    vecs[13] = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h200, 64'h0,   32'h0,    2);
    vecs[14] = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h200, 64'h0,   32'h0,    2);
    vecs[15] = mk(0, 0, 1, 0,      32'h55,   0, 1, 64'h204, 64'h200, 32'h55,   2);
    vecs[16] = mk(0, 0, 0, 0,      32'h0,    1, 0, 64'h204, 64'h0,   32'h0,    3);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst.req", imem_req, 0);
    chk("rst.valid", instr_valid, 0);
    chk("rst.pc", pc, 0);
    chk("rst.count", delivered_count, 0);
    chk("rst.instr", instr, 0);
    chk("rst.ipc", instr_pc, 0);
    reset = 1'b1;
    #1;
    chk("boot.req", imem_req, 0);

    // Directed table
    for (int i = 0; i < 17; i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].branch; imem_ack = vecs[i].ack;
      branch_target = vecs[i].target; imem_data = vecs[i].data;
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d.req", i), imem_req, vecs[i].req);
      chk($sformatf("v%0d.valid", i), instr_valid, vecs[i].valid);
      chk($sformatf("v%0d.pc", i), pc, vecs[i].pc);
      chk($sformatf("v%0d.addr", i), imem_addr, vecs[i].pc);
      chk($sformatf("v%0d.count", i), delivered_count, vecs[i].count);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d.ipc", i), instr_pc, vecs[i].ipc);
        chk($sformatf("v%0d.instr", i), instr, vecs[i].instr);
      end
    end

    // Randomized run against the model
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      stall         = ($urandom_range(0, 9) < 4);
      branch_taken  = ($urandom_range(0, 9) == 0);
      imem_ack      = ($urandom_range(0, 9) < 6);
      branch_target = {$urandom(), $urandom()};
      imem_data     = $urandom();
      model_step();
      @(posedge clk); @(negedge clk);
      chk($sformatf("r%0d.req", c), imem_req, !m_booting && !m_holding);
      chk($sformatf("r%0d.valid", c), instr_valid, m_holding);
      chk($sformatf("r%0d.pc", c), pc, m_pc);
      chk($sformatf("r%0d.addr", c), imem_addr, m_pc);
      chk($sformatf("r%0d.count", c), delivered_count, m_count);
      if (m_holding) begin
        chk($sformatf("r%0d.ipc", c), instr_pc, m_ipc);
        chk($sformatf("r%0d.instr", c), instr, m_instr);
      end
    end

    // Asynchronous reset in DELIVER, between edges
    stall = 1'b1; branch_taken = 1'b0; imem_ack = 1'b1;
    for (int c = 0; c < 20 && !instr_valid; c++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("arst.reach_deliver", instr_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.valid", instr_valid, 0);
    chk("arst.req", imem_req, 0);
    chk("arst.pc", pc, 0);
    chk("arst.count", delivered_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // PC wrap from RESET_PC = 2^64-4
    chk("wrap.rst_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    w_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("wrap.req", w_req, 1);
    chk("wrap.addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); @(negedge clk);
    chk("wrap.valid", w_valid, 1);
    chk("wrap.pc", w_pc, 64'h0);
    chk("wrap.ipc", w_ipc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.instr", w_instr, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
